// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] WEB_READ = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory-side bus of the memory port arbiter; slave = arbiter, master = pipeline and memory wrapper.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic [3:0]        dm_web;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_cs;
  logic              mem_oe;
  logic [3:0]        mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do;

  logic              pipe_stall;
  logic [31:0]       perf_if_cnt;
  logic [31:0]       perf_dm_cnt;
  logic [31:0]       perf_conf_cnt;

  modport slave (
    input  if_req, if_addr, dm_req, dm_web, dm_addr, dm_wdata, mem_do,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_cs, mem_oe, mem_web, mem_addr, mem_di, pipe_stall,
           perf_if_cnt, perf_dm_cnt, perf_conf_cnt
  );

  modport master (
    output if_req, if_addr, dm_req, dm_web, dm_addr, dm_wdata, mem_do,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_cs, mem_oe, mem_web, mem_addr, mem_di, pipe_stall,
           perf_if_cnt, perf_dm_cnt, perf_conf_cnt
  );
endinterface

// File: rtl/arb_wait_cnt.sv
// Loadable down-counter with zero flag; times the memory wait states of one access.
module arb_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the IF fetch port and the MEM data port.
// Optional performance counters are built when MEMARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_t        state;
  owner_t            owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        lat_web;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        starve_cnt;
  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_cs_q;
  logic              mem_oe_q;
  logic [3:0]        mem_web_q;

  logic gnt_slot;
  logic if_starved;
  logic if_gnt;
  logic dm_gnt;
  logic gnt_any;
  logic wait_zero;

  always_comb begin
    gnt_slot   = !rst && ((state == IDLE) || (state == RESP));
    if_starved = bus.if_req && (starve_cnt == 4'(STARVE_MAX));
    dm_gnt     = gnt_slot && bus.dm_req && !if_starved;
    if_gnt     = gnt_slot && bus.if_req && !dm_gnt;
    gnt_any    = if_gnt || dm_gnt;
  end

  arb_wait_cnt #(.W(4)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gnt_any),
    .dec      (state == BUSY),
    .load_val (4'(MEM_LAT - 1)),
    .zero     (wait_zero)
  );

  // Memory controls are registered from the next-state decision so they
  // are high exactly in the BUSY cycles, even across a RESP->BUSY grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      lat_addr    <= '0;
      lat_web     <= WEB_READ;
      lat_wdata   <= '0;
      starve_cnt  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_cs_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_web_q   <= WEB_READ;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (gnt_any) begin
            state     <= BUSY;
            owner     <= dm_gnt ? OWN_DM : OWN_IF;
            lat_addr  <= dm_gnt ? bus.dm_addr : bus.if_addr;
            lat_web   <= dm_gnt ? bus.dm_web : WEB_READ;
            lat_wdata <= dm_gnt ? bus.dm_wdata : '0;
            mem_cs_q  <= 1'b1;
            mem_oe_q  <= dm_gnt ? (bus.dm_web == WEB_READ) : 1'b1;
            mem_web_q <= dm_gnt ? bus.dm_web : WEB_READ;
          end else begin
            state     <= IDLE;
            mem_cs_q  <= 1'b0;
            mem_oe_q  <= 1'b0;
            mem_web_q <= WEB_READ;
          end
        end
        BUSY: begin
          if (wait_zero) begin
            state     <= RESP;
            mem_cs_q  <= 1'b0;
            mem_oe_q  <= 1'b0;
            mem_web_q <= WEB_READ;
            if (owner == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_do;
            end else begin
              dm_rvalid_q <= 1'b1;
              dm_rdata_q  <= (lat_web == WEB_READ) ? bus.mem_do : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (dm_gnt && bus.if_req && (starve_cnt != 4'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign bus.if_gnt     = if_gnt;
  assign bus.dm_gnt     = dm_gnt;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.dm_rvalid  = dm_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.mem_cs     = mem_cs_q;
  assign bus.mem_oe     = mem_oe_q;
  assign bus.mem_web    = mem_web_q;
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_di     = lat_wdata;
  assign bus.pipe_stall = (bus.if_req & ~if_rvalid_q) | (bus.dm_req & ~dm_rvalid_q) |
                          ((state != IDLE) & ~(if_rvalid_q | dm_rvalid_q));

`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] perf_if_q;
  logic [31:0] perf_dm_q;
  logic [31:0] perf_conf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q   <= '0;
      perf_dm_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (if_gnt) perf_if_q <= perf_if_q + 1'b1;
      if (dm_gnt) perf_dm_q <= perf_dm_q + 1'b1;
      if (bus.if_req && bus.dm_req) perf_conf_q <= perf_conf_q + 1'b1;
    end
  end

  assign bus.perf_if_cnt   = perf_if_q;
  assign bus.perf_dm_cnt   = perf_dm_q;
  assign bus.perf_conf_cnt = perf_conf_q;
`else
  assign bus.perf_if_cnt   = '0;
  assign bus.perf_dm_cnt   = '0;
  assign bus.perf_conf_cnt = '0;
`endif

  // A pending (not yet granted) request must keep its address/data stable.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    ($past(bus.if_req && !bus.if_gnt) && bus.if_req) |-> $stable(bus.if_addr));
  a_dm_hold: assert property (@(posedge clk) disable iff (rst)
    ($past(bus.dm_req && !bus.dm_gnt) && bus.dm_req) |->
      ($stable(bus.dm_addr) && $stable(bus.dm_web) && $stable(bus.dm_wdata)));

endmodule
